// File: rtl/branch_predictor_bht_if.sv
// Fetch/execute interface of the branch history table.
//   master : fetch/execute side; drives fetch_pc/fetch_is_br/fetch_valid and
//            ex_resolve/ex_taken, and receives the prediction, the stall,
//            the mispredict/resolve_err pulses and the performance counters.
//   slave  : the predictor itself.
interface branch_predictor_bht_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          fetch_pc;
    logic                 fetch_is_br;
    logic                 fetch_valid;
    logic                 pred_taken;
    logic                 fetch_stall;
    logic                 ex_resolve;
    logic                 ex_taken;
    logic                 mispredict;
    logic                 resolve_err;
    logic [CNT_WIDTH-1:0] br_count;
    logic [CNT_WIDTH-1:0] mp_count;

    modport master (
        output fetch_pc, fetch_is_br, fetch_valid, ex_resolve, ex_taken,
        input  pred_taken, fetch_stall, mispredict, resolve_err, br_count, mp_count
    );

    modport slave (
        input  fetch_pc, fetch_is_br, fetch_valid, ex_resolve, ex_taken,
        output pred_taken, fetch_stall, mispredict, resolve_err, br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of branch_predictor_bht_if
//           fetch_pc/fetch_is_br/fetch_valid -> pred_taken (combinational), fetch_stall
//           ex_resolve/ex_taken              -> mispredict, resolve_err (registered pulses)
//           br_count/mp_count                -> saturating performance counters
// Every predicted branch is queued in a small FIFO as {index, prediction} and
// popped in order when execute resolves it. A wrong prediction squashes all
// younger in-flight entries.
module branch_predictor_bht #(
    parameter int INDEX_BITS = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_predictor_bht_if.slave  bus
);
    localparam int BHT_SIZE = 2 ** INDEX_BITS;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]            bht      [BHT_SIZE];
    logic [INDEX_BITS-1:0] fifo_idx [FIFO_DEPTH];
    logic                  fifo_pred[FIFO_DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [PTR_W:0]        count;

    logic [INDEX_BITS-1:0] fetch_idx;
    logic                  full, push, pop, flush, err;
    logic                  mispredict_p1, resolve_err_p1;
    logic [CNT_WIDTH-1:0]  br_count_p1, mp_count_p1;
    logic                  unused_pc_bits;

    assign fetch_idx      = bus.fetch_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bus.fetch_pc[31:INDEX_BITS+2], bus.fetch_pc[1:0]};

    // No bypass: the prediction reads the table as it stood before this edge.
    assign bus.pred_taken  = bht[fetch_idx][1];
    assign full            = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign bus.fetch_stall = full;

    assign pop   = bus.ex_resolve && (count != '0);
    assign err   = bus.ex_resolve && (count == '0);
    assign flush = pop && (bus.ex_taken != fifo_pred[head]);
    // Stall uses pre-pop fullness, so a full FIFO never accepts a push even
    // when a slot frees up in the same cycle.
    assign push  = bus.fetch_valid && bus.fetch_is_br && !full && !flush;

    // Stage p1: table, FIFO control, pulses and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            mispredict_p1  <= 1'b0;
            resolve_err_p1 <= 1'b0;
            br_count_p1    <= '0;
            mp_count_p1    <= '0;
        end else begin
            mispredict_p1  <= flush;
            resolve_err_p1 <= err;
            if (pop) begin
                bht[fifo_idx[head]] <= ctr_update(bht[fifo_idx[head]], bus.ex_taken);
                br_count_p1         <= sat_inc(br_count_p1);
                if (flush) mp_count_p1 <= sat_inc(mp_count_p1);
            end
            if (flush) begin
                // Squash everything younger; a same-cycle push was already blocked.
                head  <= tail;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            end
        end
    end

    // FIFO payload carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[tail]  <= fetch_idx;
            fifo_pred[tail] <= bus.pred_taken;
        end
    end

    assign bus.mispredict  = mispredict_p1;
    assign bus.resolve_err = resolve_err_p1;
    assign bus.br_count    = br_count_p1;
    assign bus.mp_count    = mp_count_p1;
endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predictor_bht_if #(.CNT_WIDTH(16)) bus();

    branch_predictor_bht #(.INDEX_BITS(6), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [5:0] idx;
        logic       pred;
    } ent_t;

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  mbht [64];
    ent_t        mq [$];
    logic [1:0]  exp_q [$];
    logic [15:0] mbr, mmp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mbht[i] = 2'b01;
        mq.delete();
        exp_q.delete();
        mbr = '0;
        mmp = '0;
    endtask

    // Called at posedge+1: drive one cycle of stimulus, check the combinational
    // outputs, predict the registered ones, then check them after the edge.
    task automatic step(input logic fv, input logic br, input logic [31:0] pc,
                        input logic res, input logic tk);
        logic       ep, es, mp, er;
        logic [5:0] ix;
        ent_t       e;
        logic [1:0] got;
        bus.fetch_valid = fv;
        bus.fetch_is_br = br;
        bus.fetch_pc    = pc;
        bus.ex_resolve  = res;
        bus.ex_taken    = tk;
        #1;
        ix = pc[7:2];
        ep = mbht[ix][1];
        es = (mq.size() == 4);
        chk("pred_taken", bus.pred_taken, ep);
        chk("fetch_stall", bus.fetch_stall, es);
        mp = 1'b0;
        er = 1'b0;
        if (res) begin
            if (mq.size() == 0) er = 1'b1;
            else begin
                e = mq.pop_front();
                if (tk && mbht[e.idx] != 2'b11) mbht[e.idx] = mbht[e.idx] + 2'b01;
                if (!tk && mbht[e.idx] != 2'b00) mbht[e.idx] = mbht[e.idx] - 2'b01;
                if (mbr != 16'hFFFF) mbr = mbr + 16'd1;
                if (tk != e.pred) begin
                    mp = 1'b1;
                    if (mmp != 16'hFFFF) mmp = mmp + 16'd1;
                    mq.delete();
                end
            end
        end
        if (fv && br && !es && !mp) mq.push_back('{idx: ix, pred: ep});
        exp_q.push_back({mp, er});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            got = exp_q.pop_front();
            chk("mispredict", bus.mispredict, got[1]);
            chk("resolve_err", bus.resolve_err, got[0]);
        end
        chk("br_count", bus.br_count, mbr);
        chk("mp_count", bus.mp_count, mmp);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_is_br = 1'b0;
        bus.fetch_pc    = '0;
        bus.ex_resolve  = 1'b0;
        bus.ex_taken    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", bus.fetch_stall, 0);
        chk("rst_mispredict", bus.mispredict, 0);
        chk("rst_resolve_err", bus.resolve_err, 0);
        chk("rst_br_count", bus.br_count, 0);
        chk("rst_mp_count", bus.mp_count, 0);
        rst_n = 1'b1;

        // 1: weakly not-taken, resolved taken -> mispredict, then predicts taken
        step(1, 1, 32'h40, 0, 0);
        step(0, 0, 32'h40, 1, 1);
        idle();
        step(0, 0, 32'h40, 0, 0);
        chk("t1_pred_after", bus.pred_taken, 1);

        // 2: saturate taken, then walk down with two not-taken outcomes
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h40, 0, 0);
            step(0, 0, 32'h40, 1, 1);
        end
        step(1, 1, 32'h40, 0, 0);
        step(0, 0, 32'h40, 1, 0);
        step(0, 0, 32'h40, 0, 0);
        chk("t2_pred_10", bus.pred_taken, 1);
        step(1, 1, 32'h40, 0, 0);
        step(0, 0, 32'h40, 1, 0);
        step(0, 0, 32'h40, 0, 0);
        chk("t2_pred_01", bus.pred_taken, 0);

        // 3: fill the FIFO, blocked 5th push, one correct resolve frees a slot
        for (int i = 0; i < 4; i++) step(1, 1, 32'h100 + 32'(i * 4), 0, 0);
        step(1, 1, 32'h110, 0, 0);
        step(0, 0, 32'h0, 1, 0);
        step(1, 1, 32'h114, 0, 0);
        step(1, 1, 32'h118, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0);

        // 4: wrong resolve with a same-cycle push -> flush, then resolve_err
        for (int i = 0; i < 3; i++) step(1, 1, 32'h200 + 32'(i * 4), 0, 0);
        step(1, 1, 32'h20c, 1, 1);
        step(0, 0, 32'h0, 1, 0);
        idle();

        // 5: asynchronous reset between edges with two entries in flight
        step(1, 1, 32'h300, 0, 0);
        step(1, 1, 32'h304, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_stall", bus.fetch_stall, 0);
        chk("async_mispredict", bus.mispredict, 0);
        chk("async_resolve_err", bus.resolve_err, 0);
        chk("async_br_count", bus.br_count, 0);
        chk("async_mp_count", bus.mp_count, 0);
        bus.fetch_valid = 1'b0;
        bus.fetch_is_br = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 1, 32'h40, 0, 0);
        step(0, 0, 32'h0, 1, 1);
        idle();
        step(0, 0, 32'h40, 0, 0);
        chk("t5_bht_01", bus.pred_taken, 1);
        step(0, 0, 32'h0, 1, 0);

        // 6: 0x10000 correct resolves -> br_count saturates, mp_count holds
        step(1, 1, 32'h500, 0, 0);
        for (int i = 0; i < 65536; i++) step(1, 1, 32'h500, 1, 0);
        chk("t6_br_sat", bus.br_count, 16'hFFFF);
        chk("t6_mp_hold", bus.mp_count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
